// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI serializer among NUM_REQ requesters, with per-device CS routing.
// Optional stall watchdog enabled by defining SPI_ARB_TIMEOUT_EN.

module spi_arb_cs_lane (
    input  logic sel_i,
    input  logic busy_i,
    input  logic ser_cs_i,
    output logic cs_n_o
);
    assign cs_n_o = (busy_i && sel_i) ? ser_cs_i : 1'b1;
endmodule

module spi_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset_n,
    input  logic [NUM_REQ-1:0]           i_Req_Valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]           o_Req_Ack,
    output logic [DATA_SIZE-1:0]         o_Ser_Data,
    output logic                         o_Ser_Data_Ready,
    input  logic                         i_Ser_Ready,
    input  logic                         i_Ser_CS,
    output logic [NUM_REQ-1:0]           o_Dev_CS_n,
    output logic [$clog2(NUM_REQ)-1:0]   o_Grant_Id,
    output logic                         o_Busy,
    output logic                         o_Done,
    output logic                         o_Error
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 dready_q, dready_d;
    logic                 done_q, done_d;

    logic [IDW-1:0]       win;
    logic                 win_vld;
    logic [DATA_SIZE-1:0] win_data;
    logic                 tmo;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
    // Abort on the edge that would make the count reach the limit.
    assign tmo = (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    // Rotating priority: offset 1 from the last grant wins, so scan far-to-near and keep the last hit.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_Req_Valid[last_q + IDW'(i + 1)]) begin
                win     = last_q + IDW'(i + 1);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IDW'(k)) win_data = i_Req_Data[k*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ack_d    = '0;
        dready_d = dready_q;
        done_d   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d    = 1'b0;
        tmr_d    = (state_q != IDLE) ? tmr_q + TW'(1) : tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld && i_Ser_Ready) begin
                    state_d    = LAUNCH;
                    data_d     = win_data;
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    last_d     = win;
                    dready_d   = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmr_d      = '0;
`endif
                end
            end
            LAUNCH: begin
                if (!i_Ser_Ready) begin
                    dready_d = 1'b0;
                    state_d  = ACTIVE;
                end else if (tmo) begin
                    dready_d = 1'b0;
                    state_d  = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d    = 1'b1;
`endif
                end
            end
            ACTIVE: begin
                if (i_Ser_Ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo) begin
                    dready_d = 1'b0;
                    state_d  = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d    = 1'b1;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                dready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NUM_REQ - 1);
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            dready_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            dready_q <= dready_d;
            done_q   <= done_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end
    assign o_Error = err_q;
`else
    assign o_Error = 1'b0;
`endif

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cs
        spi_arb_cs_lane u_lane (
            .sel_i    (grant_q == IDW'(k)),
            .busy_i   (state_q != IDLE),
            .ser_cs_i (i_Ser_CS),
            .cs_n_o   (o_Dev_CS_n[k])
        );
    end

    assign o_Req_Ack        = ack_q;
    assign o_Ser_Data       = data_q;
    assign o_Ser_Data_Ready = dready_q;
    assign o_Grant_Id       = grant_q;
    assign o_Busy           = (state_q != IDLE);
    assign o_Done           = done_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: behavioural serializer plus a round-robin reference model.
module tb_spi_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   ser_data;
    logic            ser_dready;
    logic            ser_ready = 1'b1;
    logic            ser_cs = 1'b1;
    logic [N-1:0]    cs_n;
    logic [1:0]      gid;
    logic            busy, done, err;

    int checks = 0;
    int errors = 0;

    spi_tx_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Req_Valid(req_valid), .i_Req_Data(req_data),
        .o_Req_Ack(ack), .o_Ser_Data(ser_data), .o_Ser_Data_Ready(ser_dready),
        .i_Ser_Ready(ser_ready), .i_Ser_CS(ser_cs), .o_Dev_CS_n(cs_n), .o_Grant_Id(gid),
        .o_Busy(busy), .o_Done(done), .o_Error(err)
    );

    always #5 clk = ~clk;

    // Behavioural serializer: never reset by the arbiter's reset.
    int            div_cyc = 0;
    int            xfer_cyc = 3;
    bit            stuck = 1'b0;
    int            s_st = 0;
    int            s_cnt = 0;
    logic [DW-1:0] acc_q[$];

    always @(posedge clk) begin
        if (stuck) begin
            ser_ready <= 1'b1; ser_cs <= 1'b1; s_st <= 0;
        end else begin
            case (s_st)
                0: if (ser_ready && ser_dready) begin
                    if (div_cyc == 0) begin
                        ser_ready <= 1'b0; ser_cs <= 1'b0; acc_q.push_back(ser_data);
                        s_st <= 2; s_cnt <= xfer_cyc;
                    end else begin
                        s_st <= 1; s_cnt <= div_cyc - 1;
                    end
                end
                1: if (s_cnt == 0) begin
                    ser_ready <= 1'b0; ser_cs <= 1'b0; acc_q.push_back(ser_data);
                    s_st <= 2; s_cnt <= xfer_cyc;
                end else s_cnt <= s_cnt - 1;
                default: if (s_cnt == 0) begin
                    ser_ready <= 1'b1; ser_cs <= 1'b1; s_st <= 0;
                end else s_cnt <= s_cnt - 1;
            endcase
        end
    end

    int done_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    function automatic int rr(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && s_st == 0 && ser_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack(input int budget, output int id);
        id = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin id = idx_of(ack); break; end
        end
    endtask

    task automatic do_reset();
        bit ok;
        req_valid = '0;
        wait_idle(200, ok);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ack !== '0)        begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (ser_data !== '0)   begin errors++; $display("FAIL reset_data got %h exp 0", ser_data); end
        checks++; if (ser_dready !== 0)  begin errors++; $display("FAIL reset_dready got %b exp 0", ser_dready); end
        checks++; if (gid !== '0)        begin errors++; $display("FAIL reset_gid got %0d exp 0", gid); end
        checks++; if (busy !== 0 || done !== 0 || err !== 0)
            begin errors++; $display("FAIL reset_flags got busy=%b done=%b err=%b exp 0", busy, done, err); end
        checks++; if (cs_n !== 4'b1111)  begin errors++; $display("FAIL reset_cs got %b exp 1111", cs_n); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int d0;
        do_reset();
        div_cyc = 0; xfer_cyc = 6; acc_q.delete(); d0 = done_cnt;
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (ack !== 4'b0010)       begin errors++; $display("FAIL single_ack got %b exp 0010", ack); end
        checks++; if (ser_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", ser_data); end
        checks++; if (gid !== 2'd1 || ser_dready !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL single_launch got gid=%0d dr=%b busy=%b exp 1 1 1", gid, ser_dready, busy); end
        req_valid = '0;
        @(negedge clk);
        checks++; if (ack !== '0) begin errors++; $display("FAIL single_ack_pulse got %b exp 0", ack); end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ser_cs == 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL single_cs_timeout got cs never low exp low"); end
        checks++; if (cs_n !== 4'b1101) begin errors++; $display("FAIL single_cs got %b exp 1101", cs_n); end
        wait_idle(200, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok || done_cnt - d0 != 1)
            begin errors++; $display("FAIL single_done got %0d pulses (idle=%b) exp 1", done_cnt - d0, ok); end
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_accept got %0d words exp 1 deadbeef", acc_q.size()); end
    endtask

    task automatic test_contention();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int id;
        bit ok;
        do_reset();
        div_cyc = 0; xfer_cyc = 2;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 32'hA000_0000 + k;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(100, id);
            checks++; if (id != exp_ord[n]) begin errors++; $display("FAIL contention_%0d got %0d exp %0d", n, id, exp_ord[n]); end
        end
        req_valid = '0;
        wait_idle(200, ok);
    endtask

    task automatic test_fairness();
        int id;
        bit ok;
        do_reset();
        div_cyc = 0; xfer_cyc = 10;
        req_data[2*DW +: DW] = 32'h2222_2222;
        req_data[0*DW +: DW] = 32'h0000_0001;
        req_valid = 4'b0100;
        wait_ack(50, id);
        checks++; if (id != 2) begin errors++; $display("FAIL fair_first got %0d exp 2", id); end
        @(negedge clk);
        req_valid[0] = 1'b1;
        wait_ack(100, id);
        checks++; if (id != 0) begin errors++; $display("FAIL fair_second got %0d exp 0", id); end
        req_valid[0] = 1'b0;
        wait_ack(100, id);
        checks++; if (id != 2) begin errors++; $display("FAIL fair_third got %0d exp 2", id); end
        req_valid = '0;
        wait_idle(200, ok);
    endtask

    task automatic test_divided();
        int id, n0, bad;
        bit ok, seen_low;
        do_reset();
        div_cyc = 4; xfer_cyc = 3; n0 = acc_q.size(); bad = 0; seen_low = 1'b0; ok = 1'b0;
        req_data[3*DW +: DW] = 32'h3333_CAFE;
        req_valid = 4'b1000;
        wait_ack(50, id);
        req_valid = '0;
        checks++; if (id != 3) begin errors++; $display("FAIL div_ack got %0d exp 3", id); end
        for (int i = 0; i < 40; i++) begin
            if (seen_low) begin ok = (ser_dready === 1'b0); break; end
            if (ser_dready !== 1'b1) bad++;
            if (!ser_ready) seen_low = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div_hold got %0d early drops exp 0", bad); end
        checks++; if (!ok) begin errors++; $display("FAIL div_drop got dready=%b exp 0 after accept", ser_dready); end
        wait_idle(200, ok);
        checks++; if (acc_q.size() - n0 != 1) begin errors++; $display("FAIL div_once got %0d accepts exp 1", acc_q.size() - n0); end
        div_cyc = 0;
    endtask

    task automatic test_random();
        int            rem[N];
        int            mlast, e, nack, d0, bad;
        bit            ok, all_done;
        logic [N-1:0]  vprev;
        logic [N*DW-1:0] dprev;
        logic [DW-1:0] exp_q[$];
        for (int r = 0; r < 3; r++) begin
            do_reset();
            div_cyc = $urandom_range(0, 3); xfer_cyc = $urandom_range(0, 5);
            acc_q.delete(); exp_q.delete();
            mlast = N - 1; nack = 0; d0 = done_cnt; bad = 0;
            for (int k = 0; k < N; k++) rem[k] = $urandom_range(1, 4);
            vprev = req_valid; dprev = req_data;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (ack != '0) begin
                    nack++;
                    e = rr(mlast, vprev);
                    checks++;
                    if (e < 0 || ack !== (4'b0001 << e) || gid !== 2'(e) || ser_data !== dprev[e*DW +: DW]) begin
                        errors++;
                        $display("FAIL rand_grant got ack=%b gid=%0d data=%h exp id %0d data %h",
                                 ack, gid, ser_data, e, (e < 0) ? 32'h0 : dprev[e*DW +: DW]);
                    end
                    if (e >= 0) begin
                        exp_q.push_back(dprev[e*DW +: DW]);
                        mlast = e;
                        rem[e]--;
                        if (rem[e] > 0) req_data[e*DW +: DW] = $urandom();
                        else req_valid[e] = 1'b0;
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (!req_valid[k] && rem[k] > 0 && $urandom_range(0, 3) == 0) begin
                        req_data[k*DW +: DW] = $urandom();
                        req_valid[k] = 1'b1;
                    end
                end
                vprev = req_valid; dprev = req_data;
                all_done = 1'b1;
                for (int k = 0; k < N; k++) if (rem[k] > 0) all_done = 1'b0;
                if (all_done) break;
            end
            wait_idle(300, ok);
            repeat (2) @(negedge clk);
            checks++; if (!ok || acc_q.size() != exp_q.size())
                begin errors++; $display("FAIL rand_count got %0d accepted exp %0d", acc_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) if (acc_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_words got %0d bad words exp 0", bad); end
            checks++; if (done_cnt - d0 != nack) begin errors++; $display("FAIL rand_done got %0d exp %0d", done_cnt - d0, nack); end
        end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int id, cnt, d0;
        do_reset();
        stuck = 1'b1; d0 = done_cnt; cnt = 0;
        @(negedge clk);
        req_valid = 4'b0001;
        wait_ack(20, id);
        req_valid = '0;
        checks++; if (id != 0) begin errors++; $display("FAIL tmo_ack got %0d exp 0", id); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (err) break;
        end
        checks++; if (cnt != TMO) begin errors++; $display("FAIL tmo_delay got %0d exp %0d", cnt, TMO); end
        @(negedge clk);
        checks++; if (busy !== 0 || cs_n !== 4'b1111 || ser_dready !== 0 || done_cnt != d0)
            begin errors++; $display("FAIL tmo_idle got busy=%b cs=%b dr=%b done=%0d exp 0 1111 0 0",
                                     busy, cs_n, ser_dready, done_cnt - d0); end
        stuck = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int id, bad;
        bit ok, low_seen;
        do_reset();
        div_cyc = 0; xfer_cyc = 40; bad = 0; low_seen = 1'b0;
        req_data[3*DW +: DW] = 32'h5555_AAAA;
        req_valid = 4'b1000;
        wait_ack(20, id);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_cs == 1'b0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || cs_n !== 4'b0111) begin errors++; $display("FAIL mid_cs got %b exp 0111", cs_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 4'b1111 || busy !== 0 || ser_dready !== 0)
            begin errors++; $display("FAIL mid_reset got cs=%b busy=%b dr=%b exp 1111 0 0", cs_n, busy, ser_dready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser_ready) begin ok = 1'b1; break; end
            low_seen = 1'b1;
            if (ack != '0) bad++;
        end
        checks++; if (!ok || !low_seen || bad != 0 || ack !== '0)
            begin errors++; $display("FAIL mid_nogrant got %0d early acks (low=%b) exp 0", bad, low_seen); end
        @(negedge clk);
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL mid_regrant got %b exp 1000", ack); end
        req_valid = '0;
        wait_idle(300, ok);
        xfer_cyc = 3;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_divided();
        test_random();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
